gate_test_seq: RTL and testbench

GATE_TEST_SEQ -- requirements
Module: gate_test_seq

---
 rtl/gate_test_seq.sv | 131 +++++++++++++
 tb/tb_gate_test_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_test_seq.sv
// Exhaustive test sequencer for a 2-input "a AND NOT b" gate: applies {a,b} = 00,01,10,11,
// waits SETTLE cycles per vector, samples z_in once and counts mismatching vectors.
// Optional build macro GATE_TEST_STOP_ON_FAIL_EN ends the pass at the first mismatch.
module gate_test_seq #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       z_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] vec_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] ERR_MAX   = 3'd4;

  state_t     r_state;
  logic       r_start_q;
  logic [3:0] r_wait_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [2:0] r_err;
  logic [1:0] r_vec;

  logic       w_expected;
  logic       w_mismatch;
  logic [2:0] w_err_next;
  logic       w_last_vec;
  logic       w_stop;

  // The reference behaviour is a AND NOT b, judged on the vector currently driven.
  assign w_expected = r_a & ~r_b;
  assign w_mismatch = (z_in != w_expected);
  assign w_err_next = (w_mismatch && (r_err != ERR_MAX)) ? r_err + 3'd1 : r_err;
  assign w_last_vec = (r_vec == 2'd3);

`ifdef GATE_TEST_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  // start is captured for one cycle first, so APPLY begins the cycle after start is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_start_q  <= 1'b0;
      r_wait_cnt <= 4'd0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= 3'd0;
      r_vec      <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments throughout; the last one in program order wins, so this
      // default is overridden below only in the states that may accept a start request.
      r_start_q <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (r_start_q) begin
            r_state <= S_APPLY;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 3'd0;
            r_vec   <= 2'd0;
          end else begin
            r_start_q <= start;
          end
        end
        S_APPLY: begin
          r_a        <= r_vec[1];
          r_b        <= r_vec[0];
          r_wait_cnt <= WAIT_LAST;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state <= S_CHECK;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        S_CHECK: begin
          r_err <= w_err_next;
          if (w_last_vec || w_stop) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == 3'd0);
          end else begin
            r_vec   <= r_vec + 2'd1;
            r_state <= S_APPLY;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a_out     = r_a;
  assign b_out     = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign vec_idx   = r_vec;

endmodule

// File: tb/tb_gate_test_seq.sv
// Bench for gate_test_seq: two instances (SETTLE=1 and SETTLE=3) against a pass-timeline model
// that derives every output from the cycle count since the accepted start.
`timescale 1ns/1ps
module tb_gate_test_seq;

  localparam int N = 2;
`ifdef GATE_TEST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start     [N];
  logic       a_out     [N];
  logic       b_out     [N];
  logic       busy      [N];
  logic       done      [N];
  logic       pass      [N];
  logic [2:0] err_count [N];
  logic [1:0] vec_idx   [N];
  logic       z         [N];
  logic       glitch    [N];
  int         fault     [N];
  int         gmode     [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Gate under test: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 inverted.
  function automatic logic gate(input logic a, input logic b, input int f);
    case (f)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~(a & ~b);
      default: return a & ~b;
    endcase
  endfunction

  assign z[0] = gate(a_out[0], b_out[0], fault[0]) ^ glitch[0];
  assign z[1] = gate(a_out[1], b_out[1], fault[1]) ^ glitch[1];

  gate_test_seq #(.SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a_out(a_out[0]), .b_out(b_out[0]),
    .z_in(z[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err_count[0]), .vec_idx(vec_idx[0])
  );

  gate_test_seq #(.SETTLE(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a_out(a_out[1]), .b_out(b_out[1]),
    .z_in(z[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err_count[1]), .vec_idx(vec_idx[1])
  );

  // Model: a pass is a timeline of 4 slots of (SETTLE+2) cycles; slot k drives vector k in its
  // first cycle and judges z in its last cycle.
  bit m_act  [N];
  bit m_pend [N];
  bit m_done [N];
  bit m_pass [N];
  bit m_a    [N];
  bit m_b    [N];
  int m_t    [N];
  int m_err  [N];
  int m_vec  [N];

  function automatic bit in_check(input int i);
    return m_act[i] && ((m_t[i] % (settle_of(i) + 2)) == settle_of(i) + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_act[i] = 0; m_pend[i] = 0; m_done[i] = 0; m_pass[i] = 0;
        m_a[i] = 0; m_b[i] = 0; m_t[i] = 0; m_err[i] = 0; m_vec[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_act[i]) begin
          int per;
          int ph;
          int k;
          bit bad;
          per = settle_of(i) + 2;
          ph  = m_t[i] % per;
          k   = m_t[i] / per;
          if (ph == 0) begin
            m_a[i] = ((k >> 1) & 1) != 0;
            m_b[i] = (k & 1) != 0;
          end
          if (ph == per - 1) begin
            bad = (z[i] !== (m_a[i] & ~m_b[i]));
            if (bad) m_err[i] = m_err[i] + 1;
            if (k == 3 || (STOP && bad)) begin
              m_act[i]  = 0;
              m_done[i] = 1;
              m_pass[i] = (m_err[i] == 0);
            end else begin
              m_vec[i] = k + 1;
            end
          end
          m_t[i] = m_t[i] + 1;
        end else if (m_pend[i]) begin
          m_act[i] = 1; m_t[i] = 0; m_vec[i] = 0; m_err[i] = 0;
          m_done[i] = 0; m_pass[i] = 0; m_pend[i] = 0;
        end else begin
          m_pend[i] = start[i];
        end
      end
    end
  end

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Glitch mode 1 disturbs z everywhere except the judging cycle; mode 2 randomises z always.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (gmode[i] == 2 || (gmode[i] == 1 && !in_check(i))) glitch[i] = 1'($urandom_range(0, 1));
      else glitch[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      check("a_out", i, a_out[i], m_a[i]);
      check("b_out", i, b_out[i], m_b[i]);
      check("busy", i, busy[i], m_act[i]);
      check("done", i, done[i], m_done[i]);
      check("pass", i, pass[i], m_pass[i]);
      check("err_count", i, err_count[i], m_err[i]);
      check("vec_idx", i, vec_idx[i], m_vec[i]);
    end
  end

  task automatic check_all_zero(input string name);
    for (int i = 0; i < N; i++) begin
      check({name, "_a"}, i, a_out[i], 0);
      check({name, "_b"}, i, b_out[i], 0);
      check({name, "_busy"}, i, busy[i], 0);
      check({name, "_done"}, i, done[i], 0);
      check({name, "_pass"}, i, pass[i], 0);
      check({name, "_err"}, i, err_count[i], 0);
      check({name, "_vec"}, i, vec_idx[i], 0);
    end
  endtask

  // One start pulse on instance i; lat = edges from the start-sampling edge to done visible,
  // or -1 if the pass was cut by reset at edge reset_at.
  task automatic run_pass(input int i, input int f, input int gm, input int repulse_at,
                          input int reset_at, output int lat, output int busy_cyc);
    fault[i] = f;
    gmode[i] = gm;
    @(negedge clk);
    start[i] = 1'b1;
    if (!rst_n) begin
      #2 rst_n = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    start[i] = 1'b0;
    lat = 0;
    busy_cyc = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (busy[i]) busy_cyc++;
      if (lat == 1) check("done_clears", i, done[i], 0);
      if (done[i]) break;
      if (lat == repulse_at) start[i] = 1'b1;
      else if (lat == repulse_at + 1) start[i] = 1'b0;
      if (lat == reset_at) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_pass");
        start[i] = 1'b0;
        lat = -1;
        return;
      end
    end
    start[i] = 1'b0;
    check("done_seen", i, done[i], 1);
  endtask

  initial begin
    int lat;
    int bc;
    start = '{1'b0, 1'b0};
    fault = '{0, 0};
    gmode = '{0, 0};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    // Correct gate, SETTLE=1; start accepted on the first edge after reset release.
    run_pass(0, 0, 0, 0, 0, lat, bc);
    check("lat_ok", 0, lat, 13);
    check("busy_cycles_ok", 0, bc, 12);
    check("pass_ok", 0, pass[0], 1);
    check("err_ok", 0, err_count[0], 0);
    check("vec_ok", 0, vec_idx[0], 3);

    run_pass(0, 1, 0, 0, 0, lat, bc);
    check("lat_stuck0", 0, lat, STOP ? 10 : 13);
    check("pass_stuck0", 0, pass[0], 0);
    check("err_stuck0", 0, err_count[0], 1);
    check("vec_stuck0", 0, vec_idx[0], STOP ? 2 : 3);

    run_pass(0, 2, 0, 0, 0, lat, bc);
    check("lat_stuck1", 0, lat, STOP ? 4 : 13);
    check("pass_stuck1", 0, pass[0], 0);
    check("err_stuck1", 0, err_count[0], STOP ? 1 : 3);
    check("vec_stuck1", 0, vec_idx[0], STOP ? 0 : 3);

    run_pass(0, 3, 0, 0, 0, lat, bc);
    check("lat_inverted", 0, lat, STOP ? 4 : 13);
    check("err_inverted", 0, err_count[0], STOP ? 1 : 4);

    // Start re-pulsed during WAIT of vector 1 must not disturb the pass.
    run_pass(0, 0, 0, 5, 0, lat, bc);
    check("lat_repulse", 0, lat, 13);
    check("pass_repulse", 0, pass[0], 1);

    // Reset during CHECK of vector 2, then a clean pass.
    run_pass(0, 0, 0, 0, 9, lat, bc);
    check("reset_cut", 0, lat, -1);
    repeat (2) @(negedge clk);
    check("no_done_after_reset", 0, done[0], 0);
    run_pass(0, 0, 0, 0, 0, lat, bc);
    check("lat_after_reset", 0, lat, 13);
    check("pass_after_reset", 0, pass[0], 1);

    // SETTLE=3 with glitches outside the judging cycle.
    run_pass(1, 0, 1, 0, 0, lat, bc);
    check("lat_settle3", 1, lat, 21);
    check("busy_cycles_settle3", 1, bc, 20);
    check("pass_settle3", 1, pass[1], 1);
    check("err_settle3", 1, err_count[1], 0);

    for (int n = 0; n < 40; n++) begin
      int i;
      int rst_at;
      i = $urandom_range(0, 1);
      rst_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 20) : 0;
      run_pass(i, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 15), rst_at,
               lat, bc);
      if (lat < 0) repeat (2) @(negedge clk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    if (!rst_n) begin
      #2 rst_n = 1'b1;
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
